// File: rtl/conv_psum_accum_requant.sv
// Psum accumulator with bias add, rounding requantisation and int8 saturation, one output channel per start.
// Define ACCUM_RELU_EN to clamp to [0, max] (fused ReLU) instead of the full signed range.
module conv_psum_accum_requant #(
    parameter int PSUM_W = 20,
    parameter int ACC_W  = 28,
    parameter int BIAS_W = 8,
    parameter int OUT_W  = 8,
    parameter int PIX_AW = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [6:0]        cfg_in_ch,
    input  logic [PIX_AW-1:0] cfg_pix_last,
    input  logic [4:0]        cfg_shift,
    input  logic [BIAS_W-1:0] bias_in,
    input  logic              psum_valid,
    input  logic [PSUM_W-1:0] psum_in,
    output logic [OUT_W-1:0]  data_out,
    output logic              out_vaild,
    output logic              out_start,
    output logic              out_end,
    output logic              busy,
    output logic              done,
    output logic              sat_flag
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic signed [ACC_W:0] O_MAX = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [ACC_W:0] O_MIN = ~O_MAX;

    state_t                   state;
    logic                     drain_cnt;
    logic [PIX_AW-1:0]        pix_cnt, pix_last_q;
    logic [6:0]               ch_cnt, ch_last_q;
    logic [4:0]               shift_q;
    logic signed [BIAS_W-1:0] bias_q;

    logic                     s1_valid, s1_first, s1_last, s1_pstart, s1_pend;
    logic [PIX_AW-1:0]        s1_addr;
    logic signed [PSUM_W-1:0] s1_psum;
    logic signed [ACC_W-1:0]  rd_q, fwd_data_q;
    logic                     fwd_q;
    logic signed [ACC_W-1:0]  psum_buf [0:(1<<PIX_AW)-1];

    logic signed [ACC_W-1:0]  operand, psum_ext, bias_ext, acc_sum, acc_out;
    logic signed [ACC_W:0]    rnd, wide, r;
    logic [OUT_W-1:0]         q_val;
    logic                     sat, s1_wr;

    always_comb begin
        s1_wr    = s1_valid && !s1_last;
        // A one-pixel plane revisits the same address on consecutive beats; forward the pending write.
        operand  = s1_first ? '0 : (fwd_q ? fwd_data_q : rd_q);
        psum_ext = {{(ACC_W-PSUM_W){s1_psum[PSUM_W-1]}}, s1_psum};
        bias_ext = {{(ACC_W-BIAS_W){bias_q[BIAS_W-1]}}, bias_q};
        acc_sum  = operand + psum_ext;
        acc_out  = acc_sum + bias_ext;
        rnd      = ({{ACC_W{1'b0}}, 1'b1} << shift_q) >> 1;
        wide     = {acc_out[ACC_W-1], acc_out} + rnd;
        r        = wide >>> shift_q;
        sat      = 1'b0;
        q_val    = r[OUT_W-1:0];
        if (r > O_MAX) begin
            q_val = O_MAX[OUT_W-1:0];
            sat   = 1'b1;
        end
`ifdef ACCUM_RELU_EN
        else if (r < 0) begin
            q_val = '0;
        end
`else
        else if (r < O_MIN) begin
            q_val = O_MIN[OUT_W-1:0];
            sat   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (s1_wr)
            psum_buf[s1_addr] <= acc_sum;
        rd_q <= psum_buf[pix_cnt];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            drain_cnt  <= 1'b0;
            pix_cnt    <= '0;
            pix_last_q <= '0;
            ch_cnt     <= '0;
            ch_last_q  <= '0;
            shift_q    <= '0;
            bias_q     <= '0;
            s1_valid   <= 1'b0;
            s1_first   <= 1'b0;
            s1_last    <= 1'b0;
            s1_pstart  <= 1'b0;
            s1_pend    <= 1'b0;
            s1_addr    <= '0;
            s1_psum    <= '0;
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
            data_out   <= '0;
            out_vaild  <= 1'b0;
            out_start  <= 1'b0;
            out_end    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sat_flag   <= 1'b0;
        end else begin
            done       <= 1'b0;
            out_vaild  <= 1'b0;
            out_start  <= 1'b0;
            out_end    <= 1'b0;
            s1_valid   <= 1'b0;
            fwd_q      <= s1_wr && (s1_addr == pix_cnt);
            fwd_data_q <= acc_sum;

            if (s1_valid && s1_last) begin
                out_vaild <= 1'b1;
                data_out  <= q_val;
                out_start <= s1_pstart;
                out_end   <= s1_pend;
                if (sat)
                    sat_flag <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        sat_flag   <= 1'b0;
                        pix_cnt    <= '0;
                        ch_cnt     <= '0;
                        pix_last_q <= cfg_pix_last;
                        ch_last_q  <= (cfg_in_ch == 7'd0) ? 7'd0 : cfg_in_ch - 7'd1;
                        shift_q    <= cfg_shift;
                        bias_q     <= bias_in;
                    end
                end
                RUN: begin
                    if (psum_valid) begin
                        s1_valid  <= 1'b1;
                        s1_first  <= (ch_cnt == 7'd0);
                        s1_last   <= (ch_cnt == ch_last_q);
                        s1_pstart <= (pix_cnt == '0);
                        s1_pend   <= (pix_cnt == pix_last_q);
                        s1_addr   <= pix_cnt;
                        s1_psum   <= psum_in;
                        if (pix_cnt == pix_last_q) begin
                            pix_cnt <= '0;
                            ch_cnt  <= ch_cnt + 7'd1;
                            if (ch_cnt == ch_last_q) begin
                                state     <= DRAIN;
                                drain_cnt <= 1'b0;
                            end
                        end else begin
                            pix_cnt <= pix_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_psum_accum_requant.sv
// Directed bench for conv_psum_accum_requant: framing, latency, rounding, saturation, reset and ignore rules.
module tb_conv_psum_accum_requant;

    localparam int PSUM_W = 20;
    localparam int ACC_W  = 28;
    localparam int BIAS_W = 8;
    localparam int OUT_W  = 8;
    localparam int PIX_AW = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [6:0]        cfg_in_ch = '0;
    logic [PIX_AW-1:0] cfg_pix_last = '0;
    logic [4:0]        cfg_shift = '0;
    logic [BIAS_W-1:0] bias_in = '0;
    logic              psum_valid = 1'b0;
    logic [PSUM_W-1:0] psum_in = '0;
    logic [OUT_W-1:0]  data_out;
    logic              out_vaild, out_start, out_end, busy, done, sat_flag;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int q_d[$], q_s[$], q_e[$], q_c[$];
    int done_cnt = 0;
    int done_cyc = 0;
    int stim[$], expv[$];
    int first_last_cyc;

    conv_psum_accum_requant #(
        .PSUM_W(PSUM_W), .ACC_W(ACC_W), .BIAS_W(BIAS_W), .OUT_W(OUT_W), .PIX_AW(PIX_AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_in_ch(cfg_in_ch),
        .cfg_pix_last(cfg_pix_last), .cfg_shift(cfg_shift), .bias_in(bias_in),
        .psum_valid(psum_valid), .psum_in(psum_in), .data_out(data_out),
        .out_vaild(out_vaild), .out_start(out_start), .out_end(out_end),
        .busy(busy), .done(done), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_vaild) begin
            q_d.push_back(int'($signed(data_out)));
            q_s.push_back(int'(out_start));
            q_e.push_back(int'(out_end));
            q_c.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_capture();
        q_d.delete(); q_s.delete(); q_e.delete(); q_c.delete();
    endtask

    task automatic run(input string tag, input int inch, input int pl, input int sh,
                       input int b, input int bad_at, input int exp_sat);
        int nlast, d0, n, last;
        clear_capture();
        @(posedge clk); #1;
        start = 1'b1; cfg_in_ch = 7'(inch); cfg_pix_last = PIX_AW'(pl);
        cfg_shift = 5'(sh); bias_in = BIAS_W'(b);
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, ":busy_run"}, int'(busy), 1);
        nlast = ((inch == 0) ? 0 : inch - 1) * (pl + 1);
        foreach (stim[i]) begin
            psum_valid = 1'b1;
            psum_in = PSUM_W'(stim[i]);
            if (i == nlast) first_last_cyc = cyc;
            if (i == bad_at) begin
                start = 1'b1; bias_in = 8'd99; cfg_in_ch = 7'd1;
            end
            @(posedge clk); #1;
            start = 1'b0; bias_in = BIAS_W'(b); cfg_in_ch = 7'(inch);
        end
        psum_valid = 1'b0;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < 80) begin
            @(negedge clk); #1;
            n++;
        end
        chk({tag, ":done_seen"}, done_cnt - d0, 1);
        chk({tag, ":busy_at_done"}, int'(busy), 0);
        chk({tag, ":count"}, q_d.size(), expv.size());
        last = q_d.size() - 1;
        for (int i = 0; i < q_d.size() && i < expv.size(); i++) begin
            chk($sformatf("%s:data%0d", tag, i), q_d[i], expv[i]);
            chk($sformatf("%s:start%0d", tag, i), q_s[i], int'(i == 0));
            chk($sformatf("%s:end%0d", tag, i), q_e[i], int'(i == expv.size() - 1));
            if (i > 0) chk($sformatf("%s:gap%0d", tag, i), q_c[i] - q_c[i-1], 1);
        end
        if (last >= 0) begin
            chk({tag, ":latency"}, q_c[0] - first_last_cyc, 2);
            chk({tag, ":done_after_end"}, done_cyc - q_c[last], 1);
        end
        chk({tag, ":sat"}, int'(sat_flag), exp_sat);
    endtask

    task automatic scen1(input string tag);
        stim = '{1, 2, 3, 4};
        expv = '{3, 4, 5, 6};
        run(tag, 1, 3, 0, 2, -1, 0);
    endtask

    initial begin
        int d0;
        #1;
        chk("rst:out_vaild", int'(out_vaild), 0);
        chk("rst:data_out", int'(data_out), 0);
        chk("rst:busy", int'(busy), 0);
        chk("rst:done", int'(done), 0);
        chk("rst:sat", int'(sat_flag), 0);
        chk("rst:frame", int'(out_start) + int'(out_end), 0);
        #22 rst_n = 1'b1;

        scen1("s1");

        stim = '{4, 8, 4, 8, 4, 8};
        expv = '{3, 6};
        run("s2", 3, 1, 2, 0, -1, 0);

        stim = '{150, 150};
        expv = '{127};
        run("s3pos", 2, 0, 0, 0, -1, 1);

        stim = '{-150, -150};
`ifdef ACCUM_RELU_EN
        expv = '{0};
        run("s3neg", 2, 0, 0, 0, -1, 0);
`else
        expv = '{-128};
        run("s3neg", 2, 0, 0, 0, -1, 1);
`endif

        stim = '{5, -5};
        expv = '{3, -2};
        run("s4", 1, 1, 1, 0, -1, 0);

        stim = '{10, 20, 1, 2};
        expv = '{14, 25};
        run("s5start", 2, 1, 0, 3, 1, 0);

        clear_capture();
        @(posedge clk); #1;
        psum_valid = 1'b1; psum_in = PSUM_W'(1000);
        repeat (3) @(posedge clk);
        #1 psum_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("s5idle:count", q_d.size(), 0);
        chk("s5idle:busy", int'(busy), 0);

        stim = '{10, 20};
        expv = '{11, 21};
        run("s5ch0", 0, 1, 0, 1, -1, 0);

        clear_capture();
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; cfg_in_ch = 7'd2; cfg_pix_last = PIX_AW'(1);
        cfg_shift = 5'd0; bias_in = '0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            psum_valid = 1'b1; psum_in = PSUM_W'(i);
            @(posedge clk); #1;
        end
        psum_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("s6:out_vaild", int'(out_vaild), 0);
        chk("s6:busy", int'(busy), 0);
        chk("s6:data_out", int'(data_out), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("s6:no_out", q_d.size(), 0);
        chk("s6:no_done", done_cnt - d0, 0);

        scen1("s6rerun");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
